// File: rtl/tpu_spi_pkg.sv
// Shared definitions for the TPU SPI link: command codes, frame lengths,
// master FSM state encoding and small command-decoding helpers.
package tpu_spi_pkg;

    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] CMD_START  = 8'h03;
    localparam logic [7:0] CMD_STATUS = 8'h04;

    // Frame lengths in SCLK cycles, excluding the lead bits
    localparam int unsigned FRAME_BITS_WRITE  = 24;
    localparam int unsigned FRAME_BITS_READ   = 24;
    localparam int unsigned FRAME_BITS_START  = 8;
    localparam int unsigned FRAME_BITS_STATUS = 16;
    localparam int unsigned FRAME_BITS_MAX    = 24;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    function automatic logic cmd_is_legal(input logic [7:0] cmd);
        return (cmd == CMD_WRITE) || (cmd == CMD_READ) ||
               (cmd == CMD_START) || (cmd == CMD_STATUS);
    endfunction

    // Commands whose frame ends with a byte returned by the slave
    function automatic logic cmd_reads(input logic [7:0] cmd);
        return (cmd == CMD_READ) || (cmd == CMD_STATUS);
    endfunction

    function automatic logic [4:0] frame_bits(input logic [7:0] cmd);
        logic [4:0] bits;
        case (cmd)
            CMD_WRITE:  bits = 5'(FRAME_BITS_WRITE);
            CMD_READ:   bits = 5'(FRAME_BITS_READ);
            CMD_START:  bits = 5'(FRAME_BITS_START);
            CMD_STATUS: bits = 5'(FRAME_BITS_STATUS);
            default:    bits = 5'd0;
        endcase
        return bits;
    endfunction

endpackage

// File: rtl/tpu_spi_clkgen.sv
// SCLK generator: while enabled, toggles SCLK every CLK_DIV system clocks,
// starting low. Dropping the enable returns SCLK low and restarts the count.
//   i_clk, i_rst      system clock, synchronous active-high reset
//   i_en              run SCLK
//   o_sclk            registered SCLK level
//   o_rise_tick_c     high in the cycle whose closing edge raises SCLK
//   o_fall_tick_c     high in the cycle whose closing edge lowers SCLK
module tpu_spi_clkgen #(
    parameter int unsigned CLK_DIV = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise_tick_c,
    output logic o_fall_tick_c
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_sclk;
    logic             w_wrap;

    assign w_wrap        = i_en && (r_cnt == CNT_W'(CLK_DIV - 1));
    assign o_rise_tick_c = w_wrap && !r_sclk;
    assign o_fall_tick_c = w_wrap && r_sclk;
    assign o_sclk        = r_sclk;

    // Half-period counter and SCLK level
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (w_wrap) begin
            r_cnt  <= '0;
            r_sclk <= !r_sclk;
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tpu_spi_master.sv
// SPI mode 0 master for the TPU slave command protocol. Accepts one
// WRITE/READ/START/STATUS request at a time and returns a response pulse.
//   clk, rst                         system clock, synchronous active-high reset
//   req_valid/req_ready              request handshake (ready only in IDLE)
//   req_cmd, req_addr, req_wdata     request payload
//   rsp_valid, rsp_rdata, rsp_err    response pulse, read byte, illegal-cmd flag
//   busy                             not idle
//   spi_sclk, spi_mosi, spi_cs_n     SPI outputs; spi_miso SPI input
module tpu_spi_master
    import tpu_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 8,
    parameter int unsigned LEAD_BITS = 1,
    parameter int unsigned CS_GAP    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_cmd,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       busy,
    output logic       spi_sclk,
    output logic       spi_mosi,
    output logic       spi_cs_n,
    input  logic       spi_miso
);

    localparam int unsigned MAX_BITS = LEAD_BITS + FRAME_BITS_MAX;
    localparam int unsigned BIT_W    = $clog2(MAX_BITS + 1);
    localparam int unsigned CNT_MAX  = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

    state_t              r_state;
    logic                r_ready;
    logic                r_busy;
    logic                r_cs_n;
    logic [MAX_BITS-1:0] r_tx;
    logic [7:0]          r_rx;
    logic [7:0]          r_cmd;
    logic [BIT_W-1:0]    r_nbits;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_rsp_valid;
    logic                r_rsp_err;
    logic [7:0]          r_rsp_rdata;
    logic                r_miso_meta;
    logic                r_miso_sync;

    logic                w_sclk;
    logic                w_rise;
    logic                w_fall;
    logic [23:0]         w_payload;

    tpu_spi_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_en          (r_state == ST_SHIFT),
        .o_sclk        (w_sclk),
        .o_rise_tick_c (w_rise),
        .o_fall_tick_c (w_fall)
    );

    // Frame bits after the lead bits; unused trailing positions are zero,
    // which is also what MOSI must carry during read bits.
    always_comb begin
        w_payload = {req_cmd, 16'h0000};
        case (req_cmd)
            CMD_WRITE: w_payload = {req_cmd, req_addr, req_wdata};
            CMD_READ:  w_payload = {req_cmd, req_addr, 8'h00};
            default:   w_payload = {req_cmd, 16'h0000};
        endcase
    end

    // MISO synchroniser
    always_ff @(posedge clk) begin
        if (rst) begin
            r_miso_meta <= 1'b0;
            r_miso_sync <= 1'b0;
        end else begin
            r_miso_meta <= spi_miso;
            r_miso_sync <= r_miso_meta;
        end
    end

    // Transaction FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_cs_n      <= 1'b1;
            r_tx        <= '0;
            r_rx        <= '0;
            r_cmd       <= '0;
            r_nbits     <= '0;
            r_bit_cnt   <= '0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && r_ready) begin
                        if (cmd_is_legal(req_cmd)) begin
                            r_cmd     <= req_cmd;
                            r_tx      <= MAX_BITS'(w_payload);
                            r_nbits   <= BIT_W'(LEAD_BITS) + BIT_W'(frame_bits(req_cmd));
                            r_bit_cnt <= '0;
                            r_cnt     <= '0;
                            r_cs_n    <= 1'b0;
                            r_ready   <= 1'b0;
                            r_busy    <= 1'b1;
                            r_state   <= ST_SETUP;
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= 8'h00;
                        end
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == CNT_W'(CLK_DIV - 1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (w_rise) begin
                        r_rx      <= {r_rx[6:0], r_miso_sync};
                        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                    end
                    // Falling edge either advances MOSI or, after the last
                    // bit, ends the shift with SCLK back low.
                    if (w_fall) begin
                        if (r_bit_cnt == r_nbits) begin
                            r_tx    <= '0;
                            r_cnt   <= '0;
                            r_state <= ST_HOLD;
                        end else begin
                            r_tx <= r_tx << 1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == CNT_W'(CLK_DIV - 1)) begin
                        r_cnt       <= '0;
                        r_cs_n      <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= cmd_reads(r_cmd) ? r_rx : 8'h00;
                        r_state     <= ST_GAP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (r_cnt == CNT_W'(CS_GAP - 1)) begin
                        r_cnt   <= '0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_cs_n  <= 1'b1;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_ready;
    assign busy      = r_busy;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
    assign spi_cs_n  = r_cs_n;
    assign spi_sclk  = w_sclk;
    assign spi_mosi  = r_tx[MAX_BITS-1];

endmodule

// File: tb/tb_tpu_spi_master.sv
// Bench for tpu_spi_master: behavioural TPU SPI slave, response scoreboard,
// a table of single transactions and hand-written abort / back-to-back cases.
module tb_tpu_spi_master;
    import tpu_spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_cmd = 8'h00;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       busy;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_cs_n;
    logic       s_miso = 1'b0;

    always #5 clk = ~clk;

    tpu_spi_master #(.CLK_DIV(8), .LEAD_BITS(1), .CS_GAP(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cmd   (req_cmd),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_cs_n  (spi_cs_n),
        .spi_miso  (s_miso)
    );

    // ---------------- slave model ----------------
    logic [7:0] tpu_data_in = 8'h00;
    logic       tpu_busy = 1'b0;
    logic       tpu_done = 1'b0;
    logic       s_sclk_q = 1'b0;
    logic       s_cs_q = 1'b1;
    logic [7:0] s_sh = 8'h00;
    logic [7:0] s_tx = 8'h00;
    logic [7:0] s_cmd = 8'h00;
    logic [7:0] s_addr = 8'h00;
    logic [7:0] s_waddr = 8'h00;
    logic [7:0] s_wdata = 8'h00;
    int s_rise = 0, s_last_rises = 0, s_writes = 0, s_starts = 0;
    int s_cs_falls = 0, s_gap = 0, s_last_gap = 0, s_lead_err = 0;

    always @(posedge clk) begin : slave_model
        int n;
        logic [7:0] sh;
        s_sclk_q <= spi_sclk;
        s_cs_q   <= spi_cs_n;
        if (spi_cs_n) begin
            s_rise <= 0;
            s_tx   <= 8'h00;
            s_miso <= 1'b0;
            s_gap  <= s_gap + 1;
            if (!s_cs_q) s_last_rises <= s_rise;
        end else begin
            if (s_cs_q) begin
                s_cs_falls <= s_cs_falls + 1;
                s_last_gap <= s_gap;
                s_gap      <= 0;
            end
            if (spi_sclk && !s_sclk_q) begin
                n  = s_rise + 1;
                sh = {s_sh[6:0], spi_mosi};
                s_rise <= n;
                s_sh   <= sh;
                if (n == 1 && spi_mosi) s_lead_err <= s_lead_err + 1;
                if (n == 9) begin
                    s_cmd <= sh;
                    if (sh == CMD_START)  s_starts <= s_starts + 1;
                    if (sh == CMD_STATUS) s_tx <= {6'b0, tpu_done, tpu_busy};
                end
                if (n == 17) begin
                    s_addr <= sh;
                    if (s_cmd == CMD_READ) s_tx <= tpu_data_in;
                end
                if (n == 25 && s_cmd == CMD_WRITE) begin
                    s_writes <= s_writes + 1;
                    s_waddr  <= s_addr;
                    s_wdata  <= sh;
                end
            end else if (!spi_sclk && s_sclk_q) begin
                s_miso <= s_tx[7];
                s_tx   <= {s_tx[6:0], 1'b0};
            end
        end
    end

    // ---------------- checking infrastructure ----------------
    typedef struct {
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] din;
        logic       sbusy;
        logic       sdone;
        logic [7:0] exp_rdata;
        logic       exp_err;
        int         exp_rises;
        int         exp_lat;
    } vec_t;

    exp_t exp_q[$];
    int n_tests = 0, n_fail = 0;
    int cyc = 0, rsp_count = 0, last_rsp_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock; sample #1 after the edge and score any response
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (rsp_valid === 1'b1) begin
            rsp_count++;
            last_rsp_cyc = cyc;
            chk("rsp_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 3000 && req_ready !== 1'b1; i++) tick();
        chk("ready_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic do_req(input vec_t v);
        int c0, r0, w0, st0, f0;
        logic legal;
        legal = !v.exp_err;
        wait_ready();
        @(negedge clk);
        tpu_data_in = v.din;
        tpu_busy    = v.sbusy;
        tpu_done    = v.sdone;
        req_cmd     = v.cmd;
        req_addr    = v.addr;
        req_wdata   = v.wdata;
        req_valid   = 1'b1;
        exp_q.push_back('{v.exp_rdata, v.exp_err});
        c0 = cyc; r0 = rsp_count; w0 = s_writes; st0 = s_starts; f0 = s_cs_falls;
        tick();
        req_valid = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'(legal));
        for (int i = 0; i < 2000 && rsp_count == r0; i++) tick();
        chk("rsp_seen", 32'(rsp_count - r0), 32'd1);
        chk("rsp_latency", 32'(last_rsp_cyc - c0), 32'(v.exp_lat));
        wait_ready();
        tick();
        tick();
        chk("cs_frames", 32'(s_cs_falls - f0), 32'(legal));
        if (legal) chk("sclk_rises", 32'(s_last_rises), 32'(v.exp_rises));
        if (legal && (v.cmd == CMD_WRITE || v.cmd == CMD_READ))
            chk("slave_addr", 32'(s_addr), 32'(v.addr));
        chk("slave_writes", 32'(s_writes - w0), 32'(v.cmd == CMD_WRITE));
        if (v.cmd == CMD_WRITE) begin
            chk("slave_waddr", 32'(s_waddr), 32'(v.addr));
            chk("slave_wdata", 32'(s_wdata), 32'(v.wdata));
        end
        chk("slave_starts", 32'(s_starts - st0), 32'(v.cmd == CMD_START));
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs[10];

    initial begin : main
        int w0, r0, xfers, first_rsp;
        logic rdy;

        //            cmd         addr   wdata  din    bsy   dn    rdata  err   rises lat
        vecs[0] = '{CMD_WRITE,  8'h12, 8'hA5, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 25, 417};
        vecs[1] = '{CMD_READ,   8'h30, 8'h00, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 25, 417};
        vecs[2] = '{CMD_STATUS, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 17, 289};
        vecs[3] = '{CMD_START,  8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0,  9, 161};
        vecs[4] = '{8'h7F,      8'h11, 8'h22, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1,  0,   1};
        vecs[5] = '{CMD_READ,   8'h81, 8'h00, 8'hC3, 1'b0, 1'b0, 8'hC3, 1'b0, 25, 417};
        vecs[6] = '{CMD_STATUS, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h02, 1'b0, 17, 289};
        vecs[7] = '{8'h00,      8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1,  0,   1};
        vecs[8] = '{CMD_WRITE,  8'hFF, 8'h5A, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 25, 417};
        vecs[9] = '{CMD_READ,   8'h00, 8'h00, 8'h80, 1'b0, 1'b0, 8'h80, 1'b0, 25, 417};

        // Reset values
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
        chk("rst_sclk", 32'(spi_sclk), 32'd0);
        chk("rst_mosi", 32'(spi_mosi), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) do_req(vecs[i]);

        // Reset in the middle of a WRITE frame
        wait_ready();
        @(negedge clk);
        req_cmd = CMD_WRITE; req_addr = 8'h44; req_wdata = 8'h99; req_valid = 1'b1;
        w0 = s_writes;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 1000 && s_rise < 10; i++) tick();
        chk("abort_reached_bit10", 32'(s_rise >= 10), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("abort_cs_n", 32'(spi_cs_n), 32'd1);
        chk("abort_sclk", 32'(spi_sclk), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        chk("abort_no_write", 32'(s_writes - w0), 32'd0);
        do_req('{CMD_WRITE, 8'h44, 8'h99, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 25, 417});

        // Back-to-back READs with req_valid held high
        wait_ready();
        @(negedge clk);
        tpu_data_in = 8'h11;
        req_cmd = CMD_READ; req_addr = 8'h55; req_wdata = 8'h00; req_valid = 1'b1;
        exp_q.push_back('{8'h11, 1'b0});
        exp_q.push_back('{8'h22, 1'b0});
        r0 = rsp_count; xfers = 0; first_rsp = 0;
        for (int i = 0; i < 3000 && rsp_count < r0 + 2; i++) begin
            rdy = req_ready && req_valid;
            tick();
            if (rdy) begin
                xfers++;
                if (xfers == 2) req_valid = 1'b0;
            end
            if (rsp_count == r0 + 1 && first_rsp == 0) begin
                first_rsp = last_rsp_cyc;
                tpu_data_in = 8'h22;
            end
        end
        chk("b2b_rsp_count", 32'(rsp_count - r0), 32'd2);
        chk("b2b_transfers", 32'(xfers), 32'd2);
        chk("b2b_turnaround", 32'(last_rsp_cyc - first_rsp), 32'd433);
        chk("b2b_cs_gap_ge16", 32'(s_last_gap >= 16), 32'd1);

        wait_ready();
        for (int i = 0; i < 5; i++) tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("lead_bits_zero", 32'(s_lead_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
